// File: rtl/uart_rx_core_pkg.sv
// rtl/uart_rx_core_pkg.sv - shared state encodings and parity-mode constants for the UART receiver
package uart_rx_core_pkg;

  // Receiver framing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Parity modes selected by the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - received-word stream handshake between receiver and consumer
// master: receiver side, drives rx_data/rx_parity_err/rx_frame_err/rx_valid, takes rx_ready
// slave : consumer side, takes the word and flags, drives rx_ready
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_parity_err,
    output rx_frame_err,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_parity_err,
    input  rx_frame_err,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_core_rx_fifo.sv
// rtl/uart_rx_core_rx_fifo.sv - synchronous show-ahead FIFO holding received words and flags
// clk, reset   : clock, synchronous active-high reset
// push, wdata  : write request and word
// ready        : consumer pops the head when valid && ready
// rdata, valid : head word (zero while empty), non-empty flag
// count        : words held, 0..DEPTH
// overrun      : registered 1-cycle pulse when a push was dropped because the FIFO was full
module rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     ready,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = valid && ready;
  // When full, a same-cycle pop frees the slot the write pointer sits on.
  assign do_push = push && (!full || do_pop);
  assign rdata   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !do_pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver with parity/framing checks and output FIFO
// clk, reset  : oversample clock, synchronous active-high reset
// data_in     : asynchronous serial line, idle high
// rx          : received-word stream (master side of uart_rx_core_if)
// overrun     : 1-cycle pulse when a completed frame was dropped on a full FIFO
// busy        : framing FSM is not idle
// fifo_count  : words held in the FIFO
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_in,
  uart_rx_core_if.master                rx,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int WW = DATA_BITS + 2;

  logic [1:0]           sync;
  logic                 line;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 stop_idx;
  logic                 armed;
  logic                 push;
  logic [WW-1:0]        push_word;
  logic [WW-1:0]        head;
  logic                 mid_bit;
  logic                 bit_centre;

  assign line       = sync[1];
  assign mid_bit    = (cnt == CW'(OVERSAMPLE/2 - 1));
  assign bit_centre = (cnt == CW'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= 2'b11;
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      stop_idx  <= 1'b0;
      armed     <= 1'b1;
      push      <= 1'b0;
      push_word <= '0;
      busy      <= 1'b0;
    end else begin
      sync <= {sync[0], data_in};
      push <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          // After a frame ending on a low line (break), wait for idle high before re-arming.
          if (!armed) begin
            armed <= line;
          end else if (!line) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (mid_bit) begin
            cnt <= '0;
            if (line) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_centre) begin
            cnt   <= '0;
            shreg <= {line, shreg[DATA_BITS-1:1]};
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              bit_idx  <= '0;
              perr     <= 1'b0;
              ferr     <= 1'b0;
              stop_idx <= 1'b0;
              state    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_centre) begin
            cnt   <= '0;
            perr  <= ((^shreg) ^ line) != (PARITY == PAR_ODD);
            state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_centre) begin
            cnt <= '0;
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              // Return to idle on the last stop centre so a start bit half a bit later is caught.
              push      <= 1'b1;
              push_word <= {ferr | !line, perr, shreg};
              state     <= ST_IDLE;
              busy      <= 1'b0;
              armed     <= line;
            end else begin
              stop_idx <= 1'b1;
              ferr     <= ferr | !line;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  rx_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wdata   (push_word),
    .ready   (rx.rx_ready),
    .rdata   (head),
    .valid   (rx.rx_valid),
    .count   (fifo_count),
    .overrun (overrun)
  );

  assign rx.rx_data       = head[DATA_BITS-1:0];
  assign rx.rx_frame_err  = head[DATA_BITS+1];
  assign rx.rx_parity_err = (PARITY == PAR_NONE) ? 1'b0 : head[DATA_BITS];
endmodule
